// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundle of the requester byte streams, the uart_tx handshake and the
// arbiter status outputs.
//   req_valid/req_data/req_last : requester byte offers (byte i in req_data[8i+7:8i])
//   req_ready                   : one-cycle accept pulse per requester
//   tx_start/tx_data            : byte launch towards uart_tx
//   tx_busy/tx_done             : uart_tx status
//   grant_id/grant_locked       : current/last grant and frame-lock flag
//   timeout_err                 : watchdog abort pulse
// Modport slave is the arbiter; modport master is everything around it.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic [IdW-1:0]       grant_id;
  logic                 grant_locked;
  logic                 timeout_err;

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, tx_start, tx_data, grant_id, grant_locked, timeout_err
  );

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, tx_start, tx_data, grant_id, grant_locked, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte-stream requesters.
// A granted byte is launched with a one-cycle tx_start; the arbiter then waits for tx_done.
// A frame (bytes up to req_last) keeps the grant locked to one requester. A watchdog aborts
// the wait (and the frame lock) if tx_done never arrives.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_tx_arbiter_if.slave (requesters, uart_tx handshake, status)
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16384
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned    IdW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned    WdW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WdW-1:0] WdLast  = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [IdW-1:0] PtrInit = IdW'(NUM_REQ - 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e               state_q, state_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [IdW-1:0]       grant_id_q, grant_id_d;
  logic                 grant_locked_q, grant_locked_d;
  logic [WdW-1:0]       wdog_q, wdog_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [7:0]           req_bytes [NUM_REQ];
  logic                 cand_found;
  logic [IdW-1:0]       cand_idx;
  logic [IdW-1:0]       scan_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = bus.req_data[8*gi +: 8];
  end

  // Candidate selection: a locked frame only considers its owner; otherwise scan
  // ptr+1, ptr+2, ... so the most recent winner has the lowest priority.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = grant_id_q;
    scan_idx   = '0;
    if (grant_locked_q) begin
      cand_found = bus.req_valid[grant_id_q];
    end else begin
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
        scan_idx = IdW'((32'(ptr_q) + off) % NUM_REQ);
        if (!cand_found && bus.req_valid[scan_idx]) begin
          cand_found = 1'b1;
          cand_idx   = scan_idx;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_id_d     = grant_id_q;
    grant_locked_d = grant_locked_q;
    wdog_d         = wdog_q;
    tx_data_d      = tx_data_q;
    tx_start_d     = 1'b0;
    req_ready_d    = '0;
    timeout_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // tx_done is deliberately ignored here.
        if (!bus.tx_busy && cand_found) begin
          tx_start_d     = 1'b1;
          tx_data_d      = req_bytes[cand_idx];
          req_ready_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << cand_idx;
          grant_id_d     = cand_idx;
          ptr_d          = cand_idx;
          grant_locked_d = ~bus.req_last[cand_idx];
          wdog_d         = '0;
          state_d        = StWait;
        end
      end
      StWait: begin
        if (bus.tx_done) begin
          state_d = StIdle;
        end else if (wdog_q == WdLast) begin
          // Lost tx_done: drop the frame so other requesters are not starved.
          timeout_err_d  = 1'b1;
          grant_locked_d = 1'b0;
          state_d        = StIdle;
        end else begin
          wdog_d = wdog_q + WdW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ptr_q          <= PtrInit;
      grant_id_q     <= '0;
      grant_locked_q <= 1'b0;
      wdog_q         <= '0;
      tx_start_q     <= 1'b0;
      tx_data_q      <= '0;
      req_ready_q    <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      grant_id_q     <= grant_id_d;
      grant_locked_q <= grant_locked_d;
      wdog_q         <= wdog_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      req_ready_q    <= req_ready_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_locked = grant_locked_q;
  assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus for uart_tx_arbiter with a small uart_tx model and a
// transaction-level reference model that is compared against the outputs every cycle.
module tb_uart_tx_arbiter;
  localparam int unsigned NR    = 4;
  localparam int unsigned TO    = 64;
  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = 10 * (CPB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // ---------------- requester byte queues ----------------
  bit [8:0] qmem [NR][32];
  bit [4:0] qwr  [NR];
  bit [4:0] qrd  [NR];

  logic [NR-1:0]   drv_v;
  logic [NR-1:0]   drv_l;
  logic [8*NR-1:0] drv_d;

  always_comb begin
    drv_v = '0;
    drv_l = '0;
    drv_d = '0;
    for (int i = 0; i < NR; i++) begin
      drv_v[i]         = (qrd[i] != qwr[i]);
      drv_l[i]         = qmem[i][qrd[i]][8];
      drv_d[8*i +: 8]  = qmem[i][qrd[i]][7:0];
    end
  end

  assign bus.req_valid = drv_v;
  assign bus.req_last  = drv_l;
  assign bus.req_data  = drv_d;

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (bus.req_ready[i]) qrd[i] <= qrd[i] + 5'd1;
    end
  end

  task automatic push(input logic [1:0] r, input logic [7:0] d, input logic l);
    qmem[r][qwr[r]] = {l, d};
    qwr[r] = qwr[r] + 5'd1;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NR; i++) if (qrd[i] != qwr[i]) return 1'b1;
    return 1'b0;
  endfunction

  // ---------------- uart_tx model ----------------
  bit u_busy, u_done;
  int u_cnt;
  bit suppress_done, force_busy, extra_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_busy <= 1'b0;
      u_done <= 1'b0;
      u_cnt  <= 0;
    end else begin
      u_done <= 1'b0;
      if (bus.tx_start) begin
        u_busy <= 1'b1;
        u_cnt  <= 0;
      end else if (u_busy) begin
        u_cnt <= u_cnt + 1;
        if (u_cnt == FRAME - 2) u_done <= 1'b1;
        if (u_cnt == FRAME - 1) u_busy <= 1'b0;
      end
    end
  end

  assign bus.tx_busy = u_busy | force_busy;
  assign bus.tx_done = (u_done & ~suppress_done) | extra_done;

  // ---------------- reference model ----------------
  function automatic bit bit_at(input logic [NR-1:0] v, input int i);
    return (v & (NR'(1) << i)) != '0;
  endfunction

  // Next winner: the owner when locked, else first valid requester after the last winner.
  function automatic int pick_next(input logic [NR-1:0] v, input int last, input bit lock,
                                   input int owner);
    if (lock) return bit_at(v, owner) ? owner : -1;
    for (int k = 1; k <= NR; k++) if (bit_at(v, (last + k) % NR)) return (last + k) % NR;
    return -1;
  endfunction

  bit            m_wait, m_lock;
  int            m_last, m_owner, m_waited;
  int            m_pick;
  bit            e_start, e_to;
  logic [NR-1:0] e_ready;
  logic [7:0]    e_data;

  assign m_pick = pick_next(bus.req_valid, m_last, m_lock, m_owner);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 1'b0; m_lock <= 1'b0; m_last <= NR - 1; m_owner <= 0; m_waited <= 0;
      e_start <= 1'b0; e_ready <= '0; e_data <= '0; e_to <= 1'b0;
    end else begin
      e_start <= 1'b0;
      e_ready <= '0;
      e_to    <= 1'b0;
      if (!m_wait) begin
        if (!bus.tx_busy && m_pick >= 0) begin
          e_start  <= 1'b1;
          e_ready  <= NR'(1) << m_pick;
          e_data   <= 8'(bus.req_data >> (8 * m_pick));
          m_owner  <= m_pick;
          m_last   <= m_pick;
          m_lock   <= !bit_at(bus.req_last, m_pick);
          m_waited <= 0;
          m_wait   <= 1'b1;
        end
      end else if (bus.tx_done) begin
        m_wait <= 1'b0;
      end else if (m_waited + 1 == TO) begin
        e_to   <= 1'b1;
        m_lock <= 1'b0;
        m_wait <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
      end
    end
  end

  // ---------------- checking and logging ----------------
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done = 0;
  int n_log = 0;
  int n_to = 0;
  logic [1:0] log_id   [64];
  logic [7:0] log_data [64];
  logic       log_lock [64];
  int         log_cyc  [64];
  int         log_gap  [64];
  int         to_log   [16];

  int rr_id   [5] = '{0, 1, 2, 3, 0};
  int rr_data [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  int lk_id   [4] = '{1, 1, 1, 0};
  int lk_data [4] = '{8'h52, 8'h10, 8'h06, 8'hA5};
  int lk_lock [4] = '{1, 1, 0, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      checks++;
      if (bus.tx_start !== e_start || bus.req_ready !== e_ready || bus.timeout_err !== e_to ||
          bus.grant_id !== 2'(m_owner) || bus.grant_locked !== m_lock ||
          (e_start && bus.tx_data !== e_data)) begin
        failures++;
        $display("FAIL model_cycle cyc=%0d got start=%b ready=%b to=%b gid=%0d lock=%b data=%h required start=%b ready=%b to=%b gid=%0d lock=%b data=%h",
                 cyc, bus.tx_start, bus.req_ready, bus.timeout_err, bus.grant_id,
                 bus.grant_locked, bus.tx_data, e_start, e_ready, e_to, m_owner, m_lock, e_data);
      end
      if (bus.tx_start && n_log < 64) begin
        log_id[n_log]   = bus.grant_id;
        log_data[n_log] = bus.tx_data;
        log_lock[n_log] = bus.grant_locked;
        log_cyc[n_log]  = cyc;
        log_gap[n_log]  = cyc - last_done;
        n_log++;
      end
      if (bus.tx_done) last_done = cyc;
      if (bus.timeout_err && n_to < 16) begin
        to_log[n_to] = cyc;
        n_to++;
      end
    end
  endtask

  task automatic wait_quiet(input int idle_need, input string name);
    int idle = 0;
    int n = 0;
    while (idle < idle_need && n < 2000) begin
      tick();
      n++;
      if (!any_pending() && !bus.tx_busy && !bus.tx_start) idle++;
      else idle = 0;
    end
    checks++;
    if (idle < idle_need) begin
      failures++;
      $display("FAIL %s_drain got idle=%0d required idle=%0d", name, idle, idle_need);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({bus.tx_start, bus.req_ready, bus.tx_data, bus.grant_locked, bus.timeout_err,
                bus.grant_id});
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int base;
    int to_base;
    int rel;
    int n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", out_vec(), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", out_vec(), 32'd0);

    // Single request from requester 2
    push(2'd2, 8'h41, 1'b1);
    tick();
    chk("single_start", 32'(bus.tx_start), 32'd1);
    chk("single_ready", 32'(bus.req_ready), 32'b0100);
    chk("single_data", 32'(bus.tx_data), 32'h41);
    wait_quiet(4, "single");

    // All four requesting: rotating order and 2-cycle done-to-start gap
    do_reset();
    base = n_log;
    push(2'd0, 8'h10, 1'b1);
    push(2'd1, 8'h11, 1'b1);
    push(2'd2, 8'h12, 1'b1);
    push(2'd3, 8'h13, 1'b1);
    push(2'd0, 8'h14, 1'b1);
    wait_quiet(4, "rr");
    chk("rr_count", 32'(n_log - base), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_id%0d", k), 32'(log_id[base+k]), 32'(rr_id[k]));
      chk($sformatf("rr_data%0d", k), 32'(log_data[base+k]), 32'(rr_data[k]));
      if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(log_gap[base+k]), 32'd2);
    end

    // Locked 3-byte frame from requester 1 while requester 0 waits
    base = n_log;
    push(2'd1, 8'h52, 1'b0);
    push(2'd1, 8'h10, 1'b0);
    push(2'd1, 8'h06, 1'b1);
    push(2'd0, 8'hA5, 1'b1);
    wait_quiet(4, "lock");
    chk("lock_count", 32'(n_log - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lock_id%0d", k), 32'(log_id[base+k]), 32'(lk_id[k]));
      chk($sformatf("lock_data%0d", k), 32'(log_data[base+k]), 32'(lk_data[k]));
      chk($sformatf("lock_flag%0d", k), 32'(log_lock[base+k]), 32'(lk_lock[k]));
    end

    // Watchdog: tx_done never arrives; the lock must be dropped
    suppress_done = 1'b1;
    base = n_log;
    to_base = n_to;
    push(2'd2, 8'h33, 1'b0);
    push(2'd3, 8'h34, 1'b1);
    wait_quiet(TO + 4, "timeout");
    chk("to_count", 32'(n_to - to_base), 32'd2);
    chk("to_grants", 32'(n_log - base), 32'd2);
    chk("to_first_id", 32'(log_id[base]), 32'd2);
    chk("to_first_locked", 32'(log_lock[base]), 32'd1);
    chk("to_delay", 32'(to_log[to_base] - log_cyc[base]), 32'd64);
    chk("to_next_id", 32'(log_id[base+1]), 32'd3);
    chk("to_next_data", 32'(log_data[base+1]), 32'h34);
    chk("to_regrant_lat", 32'(log_cyc[base+1] - to_log[to_base]), 32'd1);
    suppress_done = 1'b0;

    // tx_busy held high blocks grants; stray tx_done in idle is ignored
    force_busy = 1'b1;
    base = n_log;
    push(2'd1, 8'h61, 1'b1);
    repeat (5) tick();
    extra_done = 1'b1;
    tick();
    extra_done = 1'b0;
    repeat (4) tick();
    chk("busy_no_start", 32'(n_log - base), 32'd0);
    force_busy = 1'b0;
    rel = cyc;
    tick();
    chk("busy_release_start", 32'(bus.tx_start), 32'd1);
    chk("busy_release_id", 32'(bus.grant_id), 32'd1);
    chk("busy_release_data", 32'(bus.tx_data), 32'h61);
    chk("busy_release_lat", 32'(log_cyc[base] - rel), 32'd1);
    wait_quiet(4, "busy");

    // Reset in the middle of a locked frame
    base = n_log;
    push(2'd3, 8'hA0, 1'b0);
    push(2'd3, 8'hA1, 1'b1);
    n = 0;
    while (n_log == base && n < 20) begin
      tick();
      n++;
    end
    chk("midrst_grant", 32'(n_log - base), 32'd1);
    repeat (5) tick();
    chk("midrst_locked", 32'(bus.grant_locked), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midrst_async_clear", out_vec(), 32'd0);
    push(2'd0, 8'h77, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    wait_quiet(4, "midrst");
    chk("midrst_count", 32'(n_log - base), 32'd3);
    chk("midrst_first_id", 32'(log_id[base+1]), 32'd0);
    chk("midrst_first_data", 32'(log_data[base+1]), 32'h77);
    chk("midrst_second_id", 32'(log_id[base+2]), 32'd3);
    chk("midrst_second_data", 32'(log_data[base+2]), 32'hA1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
